mux_rr_sched: RTL

- Round-robin scheduler that shares the 4:1 bit mux (inputs a/b/c/d, 2-bit sel, output mout) between four requesters.
- It drives the mux sel, issues a one-hot grant, and flags when mout carries the granted source.
- It sits beside the mux in the top level. It sequences ownership with a time quantum and a guard gap between owners so that consumers never sample a switching mux.

---
 rtl/mux_sched_defs.sv | 21 ++
 rtl/rr_pick4.sv | 35 +++
 rtl/mux_rr_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux_sched_defs.sv
// mux_sched_defs: definitions shared by the round-robin mux scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - NUM_SRC       : number of requesters (mux inputs a/b/c/d)
//   - SEL_W         : width of the mux select
//   - onehot()      : select index to one-hot owner vector
package mux_sched_defs;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational circular-priority search over four requests.
// Ports:
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : index searched first; search continues ptr+1, ptr+2, ptr+3 (mod 4)
//   found       out : any request set
//   idx   [1:0] out : first set request at or after ptr (ptr when none is set)
module rr_pick4
    import mux_sched_defs::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // w_cand[k] is the index visited at search step k; w_hit[k] says it is requesting.
    logic [SEL_W-1:0]   w_cand [NUM_SRC];
    logic [NUM_SRC-1:0] w_hit;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_step
        assign w_cand[gi] = ptr + SEL_W'(gi);
        assign w_hit[gi]  = req[w_cand[gi]];
    end

    assign found = |w_hit;

    always_comb begin
        idx = w_cand[0];
        if (w_hit[0])      idx = w_cand[0];
        else if (w_hit[1]) idx = w_cand[1];
        else if (w_hit[2]) idx = w_cand[2];
        else if (w_hit[3]) idx = w_cand[3];
    end

endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner scheduler for a shared 4:1 bit mux.
// Hands the mux to one requester at a time for up to QUANTUM cycles while
// others wait, and inserts GAP_CYCLES dead cycles between owners so that
// consumers never sample mout while sel is switching.
// Parameters:
//   QUANTUM    (2..255) : cycles an owner may keep the mux while others wait
//   GAP_CYCLES (0..15)  : dead cycles between owners, 0 = direct handover
// Ports:
//   sys_clk     in  : clock, all state on the rising edge
//   rst_n       in  : synchronous active-low reset
//   req   [3:0] in  : per-input request, bit0=a .. bit3=d
//   sel   [1:0] out : registered mux select
//   grant [3:0] out : registered one-hot owner, 0 when none
//   valid       out : mout currently carries the granted input
//   busy        out : scheduler in GRANT or GAP
module mux_rr_sched
    import mux_sched_defs::*;
#(
    parameter int QUANTUM    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               valid,
    output logic               busy
);

    localparam logic [7:0] Q_LAST = 8'(QUANTUM - 1);
    localparam logic [3:0] G_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    sched_state_t       r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_SRC-1:0] r_grant;
    logic               r_valid;
    logic [SEL_W-1:0]   r_ptr;
    logic [7:0]         r_qcnt;
    logic [3:0]         r_gcnt;

    sched_state_t       w_state_next;
    logic [SEL_W-1:0]   w_sel_next;
    logic [NUM_SRC-1:0] w_grant_next;
    logic               w_valid_next;
    logic [SEL_W-1:0]   w_ptr_next;
    logic [7:0]         w_qcnt_next;
    logic [3:0]         w_gcnt_next;

    logic [SEL_W-1:0]   w_pick_ptr;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [NUM_SRC-1:0] w_owner_oh;
    logic               w_others;
    logic               w_q_exp;
    logic               w_release;

    // In GRANT the only use of the picker is a zero-gap handover, which must
    // search from the pointer as it will be after release (owner + 1).
    // In IDLE and GAP the stored pointer is already the right start.
    assign w_pick_ptr = (r_state == GRANT) ? r_sel + 2'd1 : r_ptr;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_owner_oh = onehot(r_sel);
    assign w_others   = |(req & ~w_owner_oh);
    assign w_q_exp    = (r_qcnt == Q_LAST);
    assign w_release  = ~(|(req & w_owner_oh)) | (w_q_exp & w_others);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_qcnt  <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_grant <= w_grant_next;
            r_valid <= w_valid_next;
            r_ptr   <= w_ptr_next;
            r_qcnt  <= w_qcnt_next;
            r_gcnt  <= w_gcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_grant_next = r_grant;
        w_valid_next = r_valid;
        w_ptr_next   = r_ptr;
        w_qcnt_next  = r_qcnt;
        w_gcnt_next  = r_gcnt;

        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = GRANT;
                    w_sel_next   = w_idx;
                    w_grant_next = onehot(w_idx);
                    w_valid_next = 1'b1;
                    w_qcnt_next  = '0;
                end
            end

            GRANT: begin
                if (w_release) begin
                    w_grant_next = '0;
                    w_valid_next = 1'b0;
                    w_ptr_next   = r_sel + 2'd1;
                    if (GAP_CYCLES > 0) begin
                        // sel stays on the old owner through the gap
                        w_state_next = GAP;
                        w_gcnt_next  = '0;
                    end else if (w_found) begin
                        w_state_next = GRANT;
                        w_sel_next   = w_idx;
                        w_grant_next = onehot(w_idx);
                        w_valid_next = 1'b1;
                        w_qcnt_next  = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_q_exp) begin
                    // quantum used up but nobody else waiting: start a fresh quantum
                    w_qcnt_next = '0;
                end else begin
                    w_qcnt_next = r_qcnt + 8'd1;
                end
            end

            GAP: begin
                if (r_gcnt == G_LAST) begin
                    if (w_found) begin
                        w_state_next = GRANT;
                        w_sel_next   = w_idx;
                        w_grant_next = onehot(w_idx);
                        w_valid_next = 1'b1;
                        w_qcnt_next  = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_gcnt_next = r_gcnt + 4'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
                w_valid_next = 1'b0;
            end
        endcase
    end

    assign sel   = r_sel;
    assign grant = r_grant;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);

endmodule
